// File: rtl/gemcsc_slope_lut_sched.sv
// -----------------------------------------------------------------------------
// gemcsc_slope_lut_sched
//
// Schedules a batch of GEM-CSC slope lookups onto the two read ports of the
// slope ROM. One start pulse latches up to NREQ requests. Out-of-range
// addresses are answered locally with OOR_VALUE and never use a ROM cycle.
// In-range requests are served two per clock, always lowest slot index first.
//
// Ports:
//   clock        in   system clock, all logic on the rising edge
//   global_reset in   asynchronous active-high reset
//   start        in   single-cycle pulse that latches a new batch
//   req_vld      in   [NREQ] per-slot request valid, sampled with start
//   req_adr      in   [NREQ*MXADRB] packed slot addresses, sampled with start
//   rom_adr0/1   out  [MXADRB] ROM read port addresses
//   rom_rd0/1    in   [MXDATB] ROM read data, combinational from rom_adr0/1
//   res_data     out  [NREQ*MXDATB] packed per-slot results (registered)
//   res_vld      out  [NREQ] per-slot result valid (registered)
//   busy         out  high while in ISSUE or DONE
//   done         out  one-cycle pulse when the batch completes
//   overrun      out  one-cycle pulse after a start arrived while busy
// -----------------------------------------------------------------------------
module gemcsc_slope_lut_sched #(
    parameter int                NREQ      = 8,
    parameter int                MXADRB    = 7,
    parameter int                MXDATB    = 4,
    parameter int                ROMLENGTH = 80,
    parameter logic [MXDATB-1:0] OOR_VALUE = '1
) (
    input  logic                     clock,
    input  logic                     global_reset,
    input  logic                     start,
    input  logic [NREQ-1:0]          req_vld,
    input  logic [NREQ*MXADRB-1:0]   req_adr,
    output logic [MXADRB-1:0]        rom_adr0,
    output logic [MXADRB-1:0]        rom_adr1,
    input  logic [MXDATB-1:0]        rom_rd0,
    input  logic [MXDATB-1:0]        rom_rd1,
    output logic [NREQ*MXDATB-1:0]   res_data,
    output logic [NREQ-1:0]          res_vld,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One extra bit so the limit never truncates against the address width.
    localparam logic [MXADRB:0]  ROM_LIMIT = (MXADRB+1)'(ROMLENGTH);
    localparam logic [NREQ-1:0]  ONE_N     = {{(NREQ-1){1'b0}}, 1'b1};

    // Isolates the lowest set bit of a vector (one-hot, or zero if empty).
    function automatic logic [NREQ-1:0] lowest_bit(input logic [NREQ-1:0] v);
        return v & (~v + ONE_N);
    endfunction

    logic [1:0]               state_q,    state_d;
    logic [NREQ-1:0]          pending_q,  pending_d;
    logic [NREQ*MXADRB-1:0]   adr_q,      adr_d;
    logic [NREQ*MXDATB-1:0]   res_data_q, res_data_d;
    logic [NREQ-1:0]          res_vld_q,  res_vld_d;
    logic                     overrun_q,  overrun_d;

    logic [NREQ-1:0]          sel0_s;
    logic [NREQ-1:0]          sel1_s;
    logic [MXADRB-1:0]        mux0_s;
    logic [MXADRB-1:0]        mux1_s;

    // Pick the two lowest pending slots and mux out their latched addresses.
    always_comb begin
        sel0_s = lowest_bit(pending_q);
        sel1_s = lowest_bit(pending_q & ~sel0_s);
        mux0_s = '0;
        mux1_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel0_s[i]) begin
                mux0_s = mux0_s | adr_q[i*MXADRB +: MXADRB];
            end else begin
                mux0_s = mux0_s;
            end
            if (sel1_s[i]) begin
                mux1_s = mux1_s | adr_q[i*MXADRB +: MXADRB];
            end else begin
                mux1_s = mux1_s;
            end
        end
    end

    // Batch state machine: latch, serve two slots per cycle, signal completion.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        adr_d      = adr_q;
        res_data_d = res_data_q;
        res_vld_d  = res_vld_q;
        overrun_d  = start && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    adr_d      = req_adr;
                    res_vld_d  = '0;
                    res_data_d = '0;
                    pending_d  = '0;
                    for (int i = 0; i < NREQ; i++) begin
                        if (!req_vld[i]) begin
                            pending_d[i] = 1'b0;
                        end else if ({1'b0, req_adr[i*MXADRB +: MXADRB]} >= ROM_LIMIT) begin
                            // Out of range: answered here, no ROM cycle.
                            res_data_d[i*MXDATB +: MXDATB] = OOR_VALUE;
                            res_vld_d[i]                   = 1'b1;
                        end else begin
                            pending_d[i] = 1'b1;
                        end
                    end
                    state_d = (pending_d != '0) ? ST_ISSUE : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (sel0_s[i]) begin
                        res_data_d[i*MXDATB +: MXDATB] = rom_rd0;
                        res_vld_d[i]                   = 1'b1;
                        pending_d[i]                   = 1'b0;
                    end else if (sel1_s[i]) begin
                        res_data_d[i*MXDATB +: MXDATB] = rom_rd1;
                        res_vld_d[i]                   = 1'b1;
                        pending_d[i]                   = 1'b0;
                    end else begin
                        pending_d[i] = pending_q[i];
                    end
                end
                state_d = ((pending_q & ~sel0_s & ~sel1_s) == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            adr_q      <= '0;
            res_data_q <= '0;
            res_vld_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            adr_q      <= adr_d;
            res_data_q <= res_data_d;
            res_vld_q  <= res_vld_d;
            overrun_q  <= overrun_d;
        end
    end

    // ROM addresses are only driven while issuing; zero otherwise.
    assign rom_adr0 = (state_q == ST_ISSUE) ? mux0_s : '0;
    assign rom_adr1 = (state_q == ST_ISSUE) ? mux1_s : '0;

    assign res_data = res_data_q;
    assign res_vld  = res_vld_q;
    assign busy     = (state_q == ST_ISSUE) || (state_q == ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_gemcsc_slope_lut_sched.sv
module tb_gemcsc_slope_lut_sched;

    logic        clock;
    logic        global_reset;
    logic        start;
    logic [7:0]  req_vld;
    logic [55:0] req_adr;
    logic [6:0]  rom_adr0;
    logic [6:0]  rom_adr1;
    logic [3:0]  rom_rd0;
    logic [3:0]  rom_rd1;
    logic [31:0] res_data;
    logic [7:0]  res_vld;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    gemcsc_slope_lut_sched dut (
        .clock        (clock),
        .global_reset (global_reset),
        .start        (start),
        .req_vld      (req_vld),
        .req_adr      (req_adr),
        .rom_adr0     (rom_adr0),
        .rom_adr1     (rom_adr1),
        .rom_rd0      (rom_rd0),
        .rom_rd1      (rom_rd1),
        .res_data     (res_data),
        .res_vld      (res_vld),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    // ROM model: ROM[a] = a mod 16
    assign rom_rd0 = 4'(rom_adr0 % 7'd16);
    assign rom_rd1 = 4'(rom_adr1 % 7'd16);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle; sampling happens 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pulse start for one edge (edge T); returns in cycle T+1.
    task automatic do_start(input logic [7:0] vld, input logic [55:0] adr);
        req_vld = vld;
        req_adr = adr;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        global_reset = 1'b1;
        start = 1'b0; req_vld = 8'h00; req_adr = 56'h0;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
        checks++; if (res_vld !== 8'h00) begin errors++; $display("FAIL reset_res_vld: got %h want 00", res_vld); end
        checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        checks++; if ({rom_adr0, rom_adr1} !== 14'h0) begin errors++; $display("FAIL reset_rom_adr: got %0d/%0d want 0/0", rom_adr0, rom_adr1); end
        global_reset = 1'b0;
        step();
    endtask

    // All 8 slots valid with addresses 0..7; checks pairing, latency, results.
    task automatic run_full(input string tag, input bit with_overrun);
        logic [55:0] adr;
        for (int i = 0; i < 8; i++) adr[i*7 +: 7] = 7'(i);
        do_start(8'hFF, adr);
        for (int c = 0; c < 4; c++) begin
            checks++; if (rom_adr0 !== 7'(2*c) || rom_adr1 !== 7'(2*c+1)) begin
                errors++; $display("FAIL %s_pair%0d: got %0d/%0d want %0d/%0d", tag, c, rom_adr0, rom_adr1, 2*c, 2*c+1);
            end
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL %s_issue%0d_flags: busy=%0b done=%0b want 1/0", tag, c, busy, done);
            end
            if (with_overrun && c == 0) begin
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL %s_overrun_early: got %0b want 0", tag, overrun); end
                // Second start while busy: must be ignored.
                do_start(8'hFF, {8{7'd100}});
                checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL %s_overrun_pulse: got %0b want 1", tag, overrun); end
            end else begin
                step();
                if (with_overrun && c == 1) begin
                    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL %s_overrun_clear: got %0b want 0", tag, overrun); end
                end
            end
        end
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL %s_done: done=%0b busy=%0b want 1/1", tag, done, busy); end
        checks++; if (res_vld !== 8'hFF) begin errors++; $display("FAIL %s_res_vld: got %h want ff", tag, res_vld); end
        checks++; if (res_data !== 32'h76543210) begin errors++; $display("FAIL %s_res_data: got %h want 76543210", tag, res_data); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_idle: done=%0b busy=%0b want 0/0", tag, done, busy); end
        checks++; if (res_data !== 32'h76543210 || res_vld !== 8'hFF) begin errors++; $display("FAIL %s_hold: got %h/%h want 76543210/ff", tag, res_data, res_vld); end
    endtask

    task automatic test_full();
        run_full("full", 1'b0);
    endtask

    task automatic test_sparse(input string tag);
        logic [55:0] adr;
        adr = {8{7'd99}};
        adr[1*7 +: 7] = 7'd10;
        adr[4*7 +: 7] = 7'd20;
        adr[6*7 +: 7] = 7'd30;
        do_start(8'b0101_0010, adr);
        checks++; if (rom_adr0 !== 7'd10 || rom_adr1 !== 7'd20) begin errors++; $display("FAIL %s_c1: got %0d/%0d want 10/20", tag, rom_adr0, rom_adr1); end
        step();
        checks++; if (rom_adr0 !== 7'd30 || rom_adr1 !== 7'd0) begin errors++; $display("FAIL %s_c2: got %0d/%0d want 30/0", tag, rom_adr0, rom_adr1); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_early_done: got %0b want 0", tag, done); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %0b want 1", tag, done); end
        checks++; if (res_vld !== 8'b0101_0010) begin errors++; $display("FAIL %s_res_vld: got %b want 01010010", tag, res_vld); end
        checks++; if (res_data !== 32'h0E0400A0) begin errors++; $display("FAIL %s_res_data: got %h want 0e0400a0", tag, res_data); end
        step();
    endtask

    task automatic test_out_of_range();
        logic [55:0] adr;
        adr = 56'h0;
        adr[0*7 +: 7] = 7'd80;
        adr[3*7 +: 7] = 7'd127;
        adr[5*7 +: 7] = 7'd79;
        do_start(8'b0010_1001, adr);
        checks++; if (res_vld !== 8'b0000_1001 || res_data !== 32'h0000F00F) begin
            errors++; $display("FAIL oor_local: got %b/%h want 00001001/0000f00f", res_vld, res_data);
        end
        checks++; if (rom_adr0 !== 7'd79 || rom_adr1 !== 7'd0) begin errors++; $display("FAIL oor_rom: got %0d/%0d want 79/0", rom_adr0, rom_adr1); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL oor_done: got %0b want 1", done); end
        checks++; if (res_vld !== 8'b0010_1001 || res_data !== 32'h00F0F00F) begin
            errors++; $display("FAIL oor_final: got %b/%h want 00101001/00f0f00f", res_vld, res_data);
        end
        step();
    endtask

    task automatic test_empty();
        do_start(8'h00, {8{7'd5}});
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done: got %0b want 1", done); end
        checks++; if ({rom_adr0, rom_adr1} !== 14'h0) begin errors++; $display("FAIL empty_rom: got %0d/%0d want 0/0", rom_adr0, rom_adr1); end
        checks++; if (res_vld !== 8'h00 || res_data !== 32'h0) begin errors++; $display("FAIL empty_res: got %h/%h want 00/0", res_vld, res_data); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_idle: done=%0b busy=%0b want 0/0", done, busy); end
    endtask

    task automatic test_back_to_back();
        run_full("overrun", 1'b1);
    endtask

    task automatic test_reset_mid_issue();
        logic [55:0] adr;
        for (int i = 0; i < 8; i++) adr[i*7 +: 7] = 7'(i);
        do_start(8'hFF, adr);
        step();
        checks++; if (rom_adr0 !== 7'd2) begin errors++; $display("FAIL rstmid_pre: got %0d want 2", rom_adr0); end
        global_reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_flags: busy=%0b done=%0b want 0/0", busy, done); end
        checks++; if (res_vld !== 8'h00 || res_data !== 32'h0) begin errors++; $display("FAIL rstmid_res: got %h/%h want 00/0", res_vld, res_data); end
        checks++; if ({rom_adr0, rom_adr1} !== 14'h0) begin errors++; $display("FAIL rstmid_rom: got %0d/%0d want 0/0", rom_adr0, rom_adr1); end
        step();
        global_reset = 1'b0;
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_after: done=%0b busy=%0b want 0/0", done, busy); end
        test_sparse("rstmid_sparse");
    endtask

    initial begin
        test_reset();
        test_full();
        test_sparse("sparse");
        test_out_of_range();
        test_empty();
        test_back_to_back();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gemcsc_slope_lut_sched.md
Name: gemcsc_slope_lut_sched

Overview:
- Schedules a batch of GEM-CSC slope lookups onto the two read ports of the slope ROM.
- Up to NREQ lookup requests are latched per start pulse. Two requests are served per clock through rom_adr0/rom_adr1, and per-request results are collected.
- Sits between the GEM-CSC cluster matching logic and the slope ROM.
- Resolves out-of-range addresses locally, so they never consume a ROM cycle.

Parameters:
- NREQ, 8, number of request slots per batch (2..16).
- MXADRB, 7, ROM address width.
- MXDATB, 4, ROM data width.
- ROMLENGTH, 80, number of valid ROM entries; addresses >= ROMLENGTH are out of range.
- OOR_VALUE, all ones (4'hF), result returned for out-of-range addresses.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- global_reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: latch a new batch.
- req_vld  in  NREQ  per-slot request valid, sampled with start.
- req_adr  in  NREQ*MXADRB  packed slot addresses; slot i is bits [i*MXADRB +: MXADRB]; sampled with start.
- rom_adr0  out  MXADRB  ROM port 0 address.
- rom_adr1  out  MXADRB  ROM port 1 address.
- rom_rd0  in  MXDATB  ROM port 0 data, combinational from rom_adr0.
- rom_rd1  in  MXDATB  ROM port 1 data, combinational from rom_adr1.
- res_data  out  NREQ*MXDATB  packed per-slot results, registered.
- res_vld  out  NREQ  per-slot result valid, registered.
- busy  out  1  high in ISSUE and DONE.
- done  out  1  one-cycle pulse: batch complete.
- overrun  out  1  one-cycle pulse: start arrived while busy.

Behaviour:
- Reset (async, global_reset=1):
  - state=IDLE.
  - pending, res_vld, res_data, latched addresses = 0.
  - busy=done=overrun=0.
  - rom_adr0=rom_adr1=0.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - busy=0; rom_adr0/1=0.
  - On start:
    - Latch req_adr.
    - Clear res_vld and res_data.
    - For each slot with req_vld[i]=1 and adr>=ROMLENGTH: res_data[i]=OOR_VALUE, res_vld[i]=1, not pending.
    - For each slot with req_vld[i]=1 and adr<ROMLENGTH: pending[i]=1.
    - If no pending slots -> DONE; else -> ISSUE.
- ISSUE:
  - i0 = lowest set pending bit; i1 = next lowest set bit above i0.
  - rom_adr0 = adr[i0] and rom_adr1 = adr[i1], both decoded combinationally from registered pending.
  - If no i1 exists: rom_adr1=0 and port 1 data is ignored.
  - At the clock edge:
    - res_data[i0]=rom_rd0, res_vld[i0]=1, clear pending[i0].
    - If i1 exists: res_data[i1]=rom_rd1, res_vld[i1]=1, clear pending[i1].
    - If pending becomes empty -> DONE.
- DONE:
  - done=1 for exactly one cycle.
  - rom_adr0/1=0.
  - Next state IDLE.
- Latency: start sampled at edge T with k in-range requests:
  - ISSUE occupies ceil(k/2) cycles.
  - done is high in cycle T+ceil(k/2)+1 (k=0: done in cycle T+1).
  - A new start is accepted in the cycle after done.
- Results:
  - res_data/res_vld hold until the next accepted start.
  - Slots with req_vld=0 keep res_vld=0 and res_data=0.
- Start while busy (ISSUE or DONE):
  - Ignored; overrun=1 the following cycle.
  - Batch in progress is unaffected.
- Duplicate addresses across slots are looked up independently; results are identical.
- Ports are served strictly lowest index first; there is no reordering.
- Reset mid-ISSUE:
  - Immediate return to IDLE with all outputs cleared.
  - Partial results are discarded.
- Address comparison is unsigned over MXADRB bits.

Test Plan:
- ROM[a]=a mod 16, all 8 slots valid with adr 0..7 -> 4 ISSUE cycles with port pairs (0,1),(2,3),(4,5),(6,7); done at T+5; res_data slot i=i; res_vld=8'hFF.
- Slots 1,4,6 valid with adr 10,20,30 -> ISSUE cycle 1: rom_adr0=10, rom_adr1=20; cycle 2: rom_adr0=30, rom_adr1=0; done at T+3; res_vld=8'b01010010.
- Slot 0 adr=80, slot 3 adr=127, slot 5 adr=79 -> slots 0,3 get 4'hF at T+1 without a ROM cycle; slot 5 gets ROM[79]; one ISSUE cycle; done at T+2.
- start with req_vld=0 -> no ISSUE cycles; done at T+1; res_vld=0; rom_adr0/1 stay 0.
- Second start 1 cycle after an 8-request start -> overrun pulse next cycle; first batch results unchanged; done at T+5.
- global_reset asserted in the 2nd ISSUE cycle -> state IDLE, res_vld=0, busy=0, no done pulse; a subsequent start then completes normally.
